// File: rtl/count_sched_ctrl_pkg.sv
// count_pkg: shared state encoding, mode constants and default widths for the counter sequencer
package count_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int PS_W_DEF  = 4;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_BAD    = 2'd3
    } state_t;
endpackage

// File: rtl/count_sched_ctrl_prescaler_tick.sv
// prescaler_tick: synchronous divider that fires tick when the count reaches limit, then wraps to 0
module prescaler_tick #(
    parameter int PS_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [PS_W-1:0] limit,
    output logic            tick
);
    logic [PS_W-1:0] cnt_q, cnt_d;
    assign tick = en && (cnt_q == limit);
    // clear wins, otherwise advance only while enabled so a pause holds the phase
    always_comb cnt_d = clr ? '0 : en ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
    // prescaler register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/count_sched_ctrl.sv
// count_sched_ctrl: command-driven down-counter with prescaled ticks, one-shot or auto-reload
module count_sched_ctrl
    import count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PS_W  = PS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] reload_val,
    input  logic [PS_W-1:0]  prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PS_W-1:0]  prescale_q, prescale_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             tick;

    prescaler_tick #(.PS_W(PS_W)) u_ps (
        .clk   (clk),
        .rst   (rst),
        .clr   (start || stop),
        .en    (state_q == ST_RUN && !start && !stop && !pause),
        .limit (prescale_q),
        .tick  (tick)
    );

    // next state: stop beats start beats pause; ticks decrement or hit terminal count
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start) begin
            state_d    = ST_RUN;
            count_d    = reload_val;
            mode_d     = mode;
            prescale_d = prescale;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (pause) state_d = ST_PAUSED;
                    else if (tick && count_q != '0) count_d = count_q - 1'b1;
                    else if (tick) begin
                        done_d  = 1'b1;
                        count_d = (mode_q == MODE_RELOAD) ? reload_val : '0;
                        state_d = (mode_q == MODE_RELOAD) ? ST_RUN : ST_IDLE;
                    end
                end
                ST_PAUSED: state_d = pause ? ST_PAUSED : ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            prescale_q <= '0;
            mode_q     <= MODE_ONESHOT;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign state_o = state_q;
endmodule

// File: tb/tb_count_sched_ctrl.sv
// tb_count_sched_ctrl: directed stimulus pushes expected outputs per edge; a monitor pops and compares
module tb_count_sched_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, stop, pause, mode;
    logic [3:0] reload_val, prescale, count;
    logic       busy, done;
    logic [1:0] state_o;

    typedef struct {
        string      name;
        logic [3:0] c;
        logic       b;
        logic       d;
        logic [1:0] s;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0, passes = 0, fails = 0;
    bit stim_done = 1'b0;

    count_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .reload_val (reload_val),
        .prescale   (prescale),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // expected outputs after the next rising edge
    task automatic ex(input string n, input logic [3:0] c, input logic b, input logic d, input logic [1:0] s);
        exp_t e;
        @(posedge clk);
        e.name = n; e.c = c; e.b = b; e.d = d; e.s = s;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic drive(input logic st, input logic sp, input logic pa, input logic md, input logic [3:0] rv, input logic [3:0] ps);
        start = st; stop = sp; pause = pa; mode = md; reload_val = rv; prescale = ps;
    endtask

    // monitor: compare every presented cycle against the scoreboard head
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (count === e.c && busy === e.b && done === e.d && state_o === e.s) passes++;
            else begin
                fails++;
                $display("FAIL %s: got count=%0d busy=%b done=%b state=%0d, want count=%0d busy=%b done=%b state=%0d",
                         e.name, count, busy, done, state_o, e.c, e.b, e.d, e.s);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 4'd0, 4'd0);
        ex("reset", 0, 0, 0, 0);
        drive(1, 0, 0, 1, 4'd9, 4'd0);
        ex("reset_ignores_start", 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 4'd0, 4'd0);
        ex("idle", 0, 0, 0, 0);

        // one-shot basic
        drive(1, 0, 0, 0, 4'd3, 4'd0);
        ex("os_load", 3, 1, 0, 1);
        drive(0, 0, 0, 0, 4'd3, 4'd0);
        ex("os_2", 2, 1, 0, 1);
        ex("os_1", 1, 1, 0, 1);
        ex("os_0", 0, 1, 0, 1);
        ex("os_done", 0, 0, 1, 0);
        ex("os_after", 0, 0, 0, 0);
        ex("os_hold0", 0, 0, 0, 0);

        // reset mid-run
        drive(1, 0, 0, 1, 4'd5, 4'd3);
        ex("mid_load", 5, 1, 0, 1);
        drive(0, 0, 0, 1, 4'd5, 4'd3);
        ex("mid_run", 5, 1, 0, 1);
        rst = 1'b1;
        drive(1, 0, 0, 1, 4'd5, 4'd3);
        ex("mid_reset", 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 4'd5, 4'd3);
        ex("mid_reset_idle", 0, 0, 0, 0);

        // prescaled auto-reload: 2 -> 1 -> 0 -> 2 every 3 cycles, done every 9
        drive(1, 0, 0, 1, 4'd2, 4'd2);
        ex("ar_load", 2, 1, 0, 1);
        drive(0, 0, 0, 1, 4'd2, 4'd2);
        for (int k = 1; k <= 27; k++) begin
            int ph;
            ph = k % 9;
            ex("ar_period", (ph == 0 || ph < 3) ? 4'd2 : (ph < 6) ? 4'd1 : 4'd0, 1, ph == 0, 1);
        end
        drive(0, 1, 0, 1, 4'd2, 4'd2);
        ex("ar_stop", 0, 0, 0, 0);

        // pause: 5 frozen cycles (4 paused edges plus the resume edge)
        drive(1, 0, 0, 0, 4'd4, 4'd1);
        ex("pz_load", 4, 1, 0, 1);
        drive(0, 0, 0, 0, 4'd4, 4'd1);
        ex("pz_e1", 4, 1, 0, 1);
        ex("pz_e2", 3, 1, 0, 1);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) ex("pz_hold", 3, 1, 0, 2);
        pause = 1'b0;
        ex("pz_resume", 3, 1, 0, 1);
        ex("pz_e8", 3, 1, 0, 1);
        ex("pz_e9", 2, 1, 0, 1);
        ex("pz_e10", 2, 1, 0, 1);
        ex("pz_e11", 1, 1, 0, 1);
        ex("pz_e12", 1, 1, 0, 1);
        ex("pz_e13", 0, 1, 0, 1);
        ex("pz_e14", 0, 1, 0, 1);
        ex("pz_done15", 0, 0, 1, 0);

        // stop and start together: stop wins
        drive(1, 0, 0, 0, 4'd6, 4'd0);
        ex("col_load", 6, 1, 0, 1);
        drive(1, 1, 0, 0, 4'd6, 4'd0);
        ex("col_stop_start", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 4'd6, 4'd0);
        ex("col_no_done", 0, 0, 0, 0);

        // start while paused with prescaler mid-phase: restart clears it
        drive(1, 0, 0, 0, 4'd5, 4'd1);
        ex("rp_load", 5, 1, 0, 1);
        drive(0, 0, 0, 0, 4'd5, 4'd1);
        ex("rp_ps1", 5, 1, 0, 1);
        pause = 1'b1;
        ex("rp_paused", 5, 1, 0, 2);
        drive(1, 0, 1, 0, 4'd7, 4'd1);
        ex("rp_restart", 7, 1, 0, 1);
        drive(0, 0, 0, 0, 4'd7, 4'd1);
        ex("rp_ps_cleared", 7, 1, 0, 1);
        ex("rp_first_dec", 6, 1, 0, 1);
        drive(0, 1, 0, 0, 4'd7, 4'd1);
        ex("rp_stop", 0, 0, 0, 0);

        // reload_val=0 one-shot, prescale=15: done after 16 cycles
        drive(1, 0, 0, 0, 4'd0, 4'd15);
        ex("z_load", 0, 1, 0, 1);
        drive(0, 0, 0, 0, 4'd0, 4'd15);
        for (int k = 1; k < 16; k++) ex("z_wait", 0, 1, 0, 1);
        ex("z_done16", 0, 0, 1, 0);

        // reload_val=15 one-shot, prescale=0: 15 down to 0, done after 16 cycles
        drive(1, 0, 0, 0, 4'd15, 4'd0);
        ex("f_load", 15, 1, 0, 1);
        drive(0, 0, 0, 0, 4'd15, 4'd0);
        for (int k = 1; k < 16; k++) ex("f_count", 4'(15 - k), 1, 0, 1);
        ex("f_done16", 0, 0, 1, 0);
        ex("f_idle", 0, 0, 0, 0);

        // reload_val=0 auto-reload, prescale=0: done every cycle, count stays 0
        drive(1, 0, 0, 1, 4'd0, 4'd0);
        ex("zr_load", 0, 1, 0, 1);
        drive(0, 0, 0, 1, 4'd0, 4'd0);
        for (int k = 0; k < 3; k++) ex("zr_done", 0, 1, 1, 1);
        drive(0, 1, 0, 1, 4'd0, 4'd0);
        ex("zr_stop", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 4'd0, 4'd0);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/count_sched_ctrl.md
Name: count_sched_ctrl

Overview:
Sequencer for the team's 4-bit counters. It loads a programmed start value and counts down to zero at a prescaled rate. It reports each terminal count and either stops (one-shot) or reloads (auto-reload). It sits between a host/FSM issuing start/stop/pause commands and the counting datapath, replacing free-running ripple counting with a synchronous, command-driven timer.

Parameters:
WIDTH, 4, counter width in bits
PS_W, 4, prescaler width in bits; tick period = prescale+1 clk cycles

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  command: load reload_val and run; level sampled each cycle
stop  in  1  command: abort and return to IDLE
pause  in  1  level: freeze counting while high in RUN
mode  in  1  0 = one-shot, 1 = auto-reload; sampled at start
reload_val  in  WIDTH  start/reload value
prescale  in  PS_W  tick divider; sampled at start
count  out  WIDTH  current counter value
busy  out  1  high in RUN or PAUSED
done  out  1  one-cycle pulse on terminal count
state_o  out  2  current state encoding, for debug

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - state=IDLE, count=0, busy=0, done=0
  - internal prescaler=0, mode_q=0, prescale_q=0
- Reset overrides every command, including mid-run.
- States:
  - IDLE=2'd0: done=0; count holds its last value.
  - RUN=2'd1: prescaler advances.
  - PAUSED=2'd2: everything frozen.
  - 2'd3 is unused and recovers to IDLE on the next edge.
- Command priority: rst > stop > start > pause.
- stop (any state): next state IDLE; count=0; prescaler=0; no done pulse.
- start (any state, stop low):
  - count<=reload_val, prescaler<=0, mode_q<=mode, prescale_q<=prescale; next state RUN.
  - Asserting start in RUN or PAUSED restarts the timer.
- Tick: asserted combinationally in RUN when prescaler==prescale_q and start, stop and pause are all low.
  - On a non-tick RUN cycle the prescaler increments.
  - On a tick the prescaler returns to 0.
- On a tick with count!=0: count decrements by 1.
- On a tick with count==0 (terminal):
  - done=1 for exactly one cycle, registered and coincident with the next state.
  - mode_q=0: next state IDLE; count stays 0; busy drops in the same cycle done rises.
  - mode_q=1: count<=reload_val (re-sampled now); state stays RUN.
- Latency:
  - start seen at edge E gives count=reload_val and busy=1 after E.
  - The first decrement appears (prescale_q+1) edges later.
  - A one-shot with reload_val=R, prescale=P asserts done (R+1)*(P+1) edges after E.
- pause high in RUN: next state PAUSED; prescaler and count hold.
- pause low in PAUSED: return to RUN; the prescaler resumes from its held value, so no tick is lost or duplicated.
- reload_val=0:
  - One-shot: terminal on the first tick.
  - Auto-reload: done every (P+1) cycles; count stays 0.
- Wrap-around: count never underflows; the 0 to reload transition is the only path out of zero.
- busy = (state==RUN || state==PAUSED).
- Output timing: all outputs are registered or decoded purely from registered state; no input-to-output combinational path.

Decomposition:
- Shared package count_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSED
  - MODE_ONESHOT, MODE_RELOAD
  - default WIDTH/PS_W
- One natural sub-module: prescaler_tick, a synchronous PS_W-bit divider.
  - Inputs: clr, en, limit.
  - Output: tick.
  - Instantiated once.
- The down-counter and FSM stay in count_sched_ctrl.

Test Plan:
- Reset mid-run:
  - Stimulus: RUN with count=5, pulse rst for 1 cycle.
  - Required: next edge count=0, busy=0, done=0, state_o=0; start ignored while rst=1.
- One-shot basic:
  - Stimulus: reload_val=3, prescale=0, mode=0, start pulse.
  - Required: count 3,2,1,0 on successive edges; done pulses one cycle 4 edges after load; busy=0 from then; count stays 0.
- Prescaled auto-reload:
  - Stimulus: reload_val=2, prescale=2, mode=1.
  - Required: count changes every 3 cycles, 2→1→0→2; done pulses every 9 cycles for at least 3 periods.
- Pause:
  - Stimulus: one-shot reload_val=4, prescale=1; raise pause for 5 cycles just after the first decrement.
  - Required: count holds 3 and state_o=2 throughout; total time to done is exactly 10+5 cycles after load.
- Stop/start collisions:
  - Stimulus 1: stop and start high together in RUN.
  - Required: IDLE, count=0, no done.
  - Stimulus 2: start while PAUSED with reload_val=7.
  - Required: RUN, count=7, prescaler cleared.
- Edge values:
  - Stimulus: reload_val=0 one-shot with prescale=15; then reload_val=15 one-shot with prescale=0.
  - Required: done after 16 cycles in the first case; count 15 down to 0 and done after 16 cycles in the second.
